// File: rtl/instruction_fetch.sv
// Single-outstanding-request instruction fetch unit: issues word fetches,
// buffers one instruction for decode, and handles redirects mid-flight.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] VALID = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] target;

  assign target    = redirect_pc & 32'hFFFF_FFFC;
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = req_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= 32'h0;
      if_pc    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (redirect) begin
            pc       <= target;
            req_addr <= target;
          end else begin
            req_addr <= pc;
          end
        end
        FETCH: begin
          if (redirect) begin
            pc <= target;
            // With ack the bus is free: reissue at the target right away.
            if (imem_ack) req_addr <= target;
            else          state    <= DRAIN;
          end else if (imem_ack) begin
            if_instr <= imem_rdata;
            if_pc    <= req_addr;
            if_valid <= 1'b1;
            pc       <= req_addr + 32'd4;
            state    <= VALID;
          end
        end
        DRAIN: begin
          // A redirect coinciding with the drained ack still retires the
          // stale request; the newest target is fetched next.
          if (redirect) pc <= target;
          if (imem_ack) begin
            state    <= FETCH;
            req_addr <= redirect ? target : pc;
          end
        end
        VALID: begin
          if (redirect) begin
            if_valid <= 1'b0;
            pc       <= target;
            req_addr <= target;
            state    <= FETCH;
          end else if (if_ready) begin
            if_valid <= 1'b0;
            req_addr <= pc;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized checks of instruction_fetch against a request/buffer
// level reference model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc2;

  int tests = 0;
  int fails = 0;

  // reference model: request outstanding, its address, whether its data is
  // stale, the next fetch address, and the decode buffer
  logic        m_busy, m_drop, m_have;
  logic [31:0] m_addr, m_next, m_instr, m_ipc;

  logic [31:0] wrap_q[$];

  instruction_fetch dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(1'b1), .imem_rdata(32'h0000_0013), .redirect(1'b0),
    .redirect_pc(32'h0), .if_valid(valid2), .if_ready(1'b1),
    .if_instr(instr2), .if_pc(pc2)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset === 1'b0 && req2 === 1'b1 && wrap_q.size() < 4) wrap_q.push_back(addr2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    tgt = redirect_pc & 32'hFFFF_FFFC;
    if (reset) begin
      m_busy = 0; m_drop = 0; m_have = 0;
      m_addr = 32'h0; m_next = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
    end else if (m_busy) begin
      if (imem_ack) begin
        if (redirect) begin
          m_addr = tgt; m_next = tgt; m_drop = 0;
        end else if (m_drop) begin
          m_addr = m_next; m_drop = 0;
        end else begin
          m_have = 1; m_instr = imem_rdata; m_ipc = m_addr;
          m_next = m_addr + 32'd4; m_busy = 0;
        end
      end else if (redirect) begin
        m_next = tgt; m_drop = 1;
      end
    end else if (m_have) begin
      if (redirect) begin
        m_have = 0; m_addr = tgt; m_next = tgt; m_busy = 1;
      end else if (if_ready) begin
        m_have = 0; m_addr = m_next; m_busy = 1;
      end
    end else begin
      if (redirect) m_next = tgt;
      m_addr = m_next; m_busy = 1;
    end
  endtask

  task automatic compare();
    chk("imem_req", 32'(imem_req), 32'(m_busy));
    if (m_busy) chk("imem_addr", imem_addr, m_addr);
    chk("if_valid", 32'(if_valid), 32'(m_have));
    chk("if_instr", if_instr, m_instr);
    chk("if_pc", if_pc, m_ipc);
  endtask

  task automatic step(input logic r, input logic a, input logic rdy, input logic rd,
                      input logic [31:0] rpc, input logic [31:0] data);
    reset = r; imem_ack = a; if_ready = rdy; redirect = rd;
    redirect_pc = rpc; imem_rdata = data;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  initial begin
    // reset, with other inputs active to show reset overrides them
    step(1, 1, 1, 1, 32'h40, 32'hDEAD_BEEF);
    step(1, 1, 1, 1, 32'h40, 32'hDEAD_BEEF);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);

    // back-to-back stream, ack with every request, decode always ready
    step(0, 1, 1, 0, 0, 32'h1111_0001);
    chk("seq_addr0", imem_addr, 32'h0);
    step(0, 1, 1, 0, 0, 32'h1111_0002);
    chk("seq_pc0", if_pc, 32'h0);
    step(0, 1, 1, 0, 0, 32'h1111_0003);
    chk("seq_addr1", imem_addr, 32'h4);
    step(0, 1, 1, 0, 0, 32'h1111_0004);
    chk("seq_pc1", if_pc, 32'h4);
    step(0, 1, 1, 0, 0, 32'h1111_0005);
    chk("seq_addr2", imem_addr, 32'h8);
    step(0, 1, 1, 0, 0, 32'h1111_0006);
    chk("seq_pc2", if_pc, 32'h8);

    // decode stall holds the buffered instruction
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 32'h0050_0093);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0, $urandom);
      chk("stall_instr", if_instr, 32'h0050_0093);
      chk("stall_pc", if_pc, 32'h0000_000C);
      chk("stall_req", 32'(imem_req), 32'h0);
    end
    step(0, 0, 1, 0, 0, 0);
    chk("resume_addr", imem_addr, 32'h10);

    // redirect while a request is outstanding: drain, then refetch
    step(0, 0, 0, 1, 32'h100, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("drain_addr", imem_addr, 32'h10);
      chk("drain_valid", 32'(if_valid), 32'h0);
    end
    step(0, 1, 0, 0, 0, 32'hBAD0_BAD0);
    chk("drain_drop", 32'(if_valid), 32'h0);
    chk("redir_addr", imem_addr, 32'h100);
    step(0, 1, 0, 0, 0, 32'h0000_0113);
    chk("redir_pc", if_pc, 32'h100);

    // misaligned redirect during a completing handshake
    step(0, 0, 1, 1, 32'h203, 0);
    chk("valid_redir_v", 32'(if_valid), 32'h0);
    chk("valid_redir_a", imem_addr, 32'h200);
    step(0, 1, 0, 0, 0, 32'h0000_0213);
    chk("valid_redir_pc", if_pc, 32'h200);

    // reset in the middle of a drain, with a late ack afterwards
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 32'h300, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("drain_rst_req", 32'(imem_req), 32'h0);
    step(0, 1, 0, 0, 0, 32'hBAD1_BAD1);
    chk("post_rst_valid", 32'(if_valid), 32'h0);
    chk("post_rst_addr", imem_addr, 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0),
           $urandom, $urandom);

    // PC wrap from the top of the address space
    chk("wrap_count", 32'(wrap_q.size() >= 2), 32'h1);
    if (wrap_q.size() >= 2) begin
      chk("wrap_addr0", wrap_q[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", wrap_q[1], 32'h0000_0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word-aligned fetch address; valid while imem_req=1.
REQ-006 imem_ack  input  1  memory returns imem_rdata this cycle for the request in flight.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 redirect  input  1  taken branch/jump; restart fetch at redirect_pc.
REQ-009 redirect_pc  input  32  redirect target address.
REQ-010 if_valid  output  1  if_instr/if_pc hold a valid instruction for decode/immediate generation.
REQ-011 if_ready  input  1  decode accepts the instruction this cycle.
REQ-012 if_instr  output  32  fetched instruction.
REQ-013 if_pc  output  32  address of if_instr.

Function
REQ-014 States SHALL be IDLE, FETCH, DRAIN, VALID; registered state, no combinational path from imem_ack/if_ready/redirect to any output.
REQ-015 Internal next-PC register pc; req_addr register drives imem_addr.
REQ-016 IDLE: imem_req=0; next cycle SHALL enter FETCH with req_addr<=pc.
REQ-017 FETCH: imem_req=1; imem_addr SHALL stay stable until the cycle imem_ack=1.
REQ-018 FETCH, imem_ack=1, redirect=0: if_instr<=imem_rdata, if_pc<=req_addr, if_valid<=1, pc<=req_addr+4, go VALID.
REQ-019 VALID: if_valid=1; if_instr/if_pc SHALL hold stable while if_ready=0.
REQ-020 VALID, if_ready=1, redirect=0: if_valid<=0, req_addr<=pc, go FETCH (issue-to-issue minimum 2 cycles).
REQ-021 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 redirect SHALL have priority over every other event in every state.
REQ-023 redirect in IDLE or VALID: if_valid<=0, pc and req_addr<={redirect_pc[31:2],2'b00}, go FETCH; in VALID with if_ready=1 the handshake counts as completed.
REQ-024 redirect in FETCH with imem_ack=1: imem_rdata discarded, req_addr<=aligned target, stay FETCH (imem_req stays 1).
REQ-025 redirect in FETCH with imem_ack=0: outstanding request SHALL NOT be aborted; pc<=aligned target, go DRAIN.
REQ-026 DRAIN: imem_req=1, imem_addr unchanged; on imem_ack data discarded, req_addr<=pc, go FETCH; if_valid SHALL stay 0.
REQ-027 redirect in DRAIN: pc<=new aligned target (latest wins), remain DRAIN.
REQ-028 redirect_pc[1:0] SHALL be ignored (forced to 2'b00); no exception raised.
REQ-029 imem_ack in IDLE or VALID SHALL be ignored.
REQ-030 At most one memory request outstanding at any time.

Reset
REQ-031 reset=1 SHALL force: state IDLE, pc=RESET_PC, req_addr=RESET_PC, imem_req=0, if_valid=0, if_instr=0, if_pc=0 at the next edge.
REQ-032 reset asserted mid-request SHALL drop imem_req next cycle; any later imem_ack before first FETCH ignored.
REQ-033 reset overrides redirect, imem_ack and if_ready.

Verification
REQ-034 Reset release, imem_ack same cycle as every request, if_ready=1 -> imem_addr sequence 0x0,0x4,0x8; if_pc matches; one instruction per 2 cycles.
REQ-035 if_ready=0 for 5 cycles while VALID with if_instr=32'h00500093 -> if_instr, if_pc constant, imem_req=0 throughout; fetch resumes at if_pc+4 after handshake.
REQ-036 redirect to 0x100 in FETCH with ack delayed 3 cycles -> imem_addr held, returned word dropped, if_valid stays 0, next imem_addr=0x100.
REQ-037 redirect to 0x203 in VALID with if_ready=1 -> if_valid 0 next cycle, next imem_addr=0x200.
REQ-038 RESET_PC=32'hFFFF_FFFC, two fetches -> imem_addr 0xFFFF_FFFC then 0x0000_0000.
REQ-039 reset pulsed in DRAIN, late imem_ack after -> state IDLE, if_valid=0, first fetch at RESET_PC.
